// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI slave model of main memory (AW/W/B, AR/R, INCR only).
// Word-addressed storage, fixed read latency, one read and one write in flight.
// Ports: clk, rst (sync, active-high); AW*/W*/B* write path; AR*/R* read path;
//   protocol_err sticky flag for write-burst framing/ID violations.
// Option: define AXI_MEM_BACKPRESSURE_EN for LFSR-driven ready/R-beat stalls.
module axi_mem_responder #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 16384,
  parameter int READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  protocol_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_BURST
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Only the word-index bits of the addresses matter.
  logic unused_addr;
  assign unused_addr = ^{AWADDR, ARADDR};

  // Low while in reset so every ready is 0 then, without
  // a combinational path from rst to the outputs.
  logic live_q;

  always_ff @(posedge clk) begin
    if (rst) live_q <= 1'b0;
    else     live_q <= 1'b1;
  end

  logic stall_rdy;
  logic stall_r;

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall_rdy = lfsr_q[0];
  assign stall_r   = lfsr_q[1];
`else
  assign stall_rdy = 1'b0;
  assign stall_r   = 1'b0;
`endif

  // ---------------- read path ----------------
  r_state_t              r_state_q, r_state_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic [3:0]            r_len_q, r_len_d;
  logic [3:0]            r_beat_q, r_beat_d;
  idx_t                  r_idx_q, r_idx_d;
  logic [3:0]            rid_q, rid_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  r_load;
  idx_t                  r_load_idx;
  logic                  pres;
  idx_t                  pres_idx;
  logic                  pres_last;
  logic                  ar_hs;
  logic                  r_hs;

  assign ARREADY = live_q & (r_state_q == R_IDLE) & ~stall_rdy;
  assign ar_hs   = ARVALID & ARREADY;
  assign r_hs    = rvalid_q & RREADY;

  always_comb begin
    r_state_d  = r_state_q;
    r_cnt_d    = r_cnt_q;
    r_len_d    = r_len_q;
    r_beat_d   = r_beat_q;
    r_idx_d    = r_idx_q;
    rid_d      = rid_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    r_load     = 1'b0;
    r_load_idx = r_idx_q;
    pres       = 1'b0;
    pres_idx   = r_idx_q;
    pres_last  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rid_d    = ARID;
          r_len_d  = ARLEN;
          r_beat_d = 4'd0;
          r_idx_d  = ARADDR[IW+1:2];
          if (READ_LATENCY == 1) begin
            r_state_d = R_BURST;
            pres      = 1'b1;
            pres_idx  = ARADDR[IW+1:2];
            pres_last = (ARLEN == 4'd0);
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = 4'(READ_LATENCY - 1);
          end
        end
      end
      R_WAIT: begin
        // Counter holds the cycles left before RVALID.
        if (r_cnt_q == 4'd1) begin
          r_state_d = R_BURST;
          pres      = 1'b1;
          pres_last = (r_len_q == 4'd0);
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_BURST: begin
        if (!rvalid_q) begin
          // A beat postponed by a stall is presented now.
          pres      = 1'b1;
          pres_last = (r_beat_q == r_len_q);
        end else if (r_hs) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_idx_d   = r_idx_q + 1'b1;
            r_beat_d  = r_beat_q + 4'd1;
            pres      = 1'b1;
            pres_idx  = r_idx_q + 1'b1;
            pres_last = ((r_beat_q + 4'd1) == r_len_q);
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
    if (pres) begin
      if (!stall_r) begin
        r_load     = 1'b1;
        r_load_idx = pres_idx;
        rvalid_d   = 1'b1;
        rlast_d    = pres_last;
      end else begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_idx_q   <= '0;
      rid_q     <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_idx_q   <= r_idx_d;
      rid_q     <= rid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      // Same-edge write to this word is not yet visible here.
      if (r_load) rdata_q <= mem[r_load_idx];
    end
  end

  assign RVALID = rvalid_q;
  assign RLAST  = rlast_q;
  assign RID    = rid_q;
  assign RDATA  = rdata_q;

  // ---------------- write path ----------------
  w_state_t   w_state_q, w_state_d;
  logic [3:0] w_len_q, w_len_d;
  logic [3:0] w_beat_q, w_beat_d;
  idx_t       w_idx_q, w_idx_d;
  logic [3:0] bid_q, bid_d;
  logic       err_q, err_d;
  logic       w_we;
  logic       w_fin;
  logic       aw_hs;
  logic       w_hs;

  assign AWREADY = live_q & (w_state_q == W_IDLE) & ~stall_rdy;
  assign WREADY  = live_q & (w_state_q == W_DATA) & ~stall_rdy;
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign w_fin   = (w_beat_q == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_idx_d   = w_idx_q;
    bid_d     = bid_q;
    err_d     = err_q;
    w_we      = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          bid_d     = AWID;
          w_len_d   = AWLEN;
          w_beat_d  = 4'd0;
          w_idx_d   = AWADDR[IW+1:2];
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_we     = 1'b1;
          w_idx_d  = w_idx_q + 1'b1;
          w_beat_d = w_beat_q + 4'd1;
          // WLAST is only checked; the beat count ends the burst.
          if ((WLAST != w_fin) || (WID != bid_q)) err_d = 1'b1;
          if (w_fin) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) w_state_d = W_IDLE;
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_idx_q   <= '0;
      bid_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_idx_q   <= w_idx_d;
      bid_q     <= bid_d;
      err_q     <= err_d;
    end
  end

  // Storage is never reset and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (w_we && !rst) mem[w_idx_q] <= WDATA;
  end

  assign BVALID       = (w_state_q == W_RESP);
  assign BID          = bid_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed + randomized checks of axi_mem_responder
// against a word-array reference model of memory and AXI timing rules.
module tb_axi_mem_responder;

  localparam int DEPTH = 16384;
  localparam int RLAT  = 4;

  logic        clk;
  logic        rst;
  logic        AWVALID, AWREADY;
  logic [3:0]  AWID, AWLEN;
  logic [25:0] AWADDR;
  logic        WVALID, WREADY, WLAST;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic        BVALID, BREADY;
  logic [3:0]  BID;
  logic        ARVALID, ARREADY;
  logic [3:0]  ARID, ARLEN;
  logic [25:0] ARADDR;
  logic        RVALID, RREADY, RLAST;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic        protocol_err;

  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID),
    .AWLEN(AWLEN), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .WID(WID), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID),
    .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .RID(RID), .RDATA(RDATA),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] wbuf [16];

  task automatic chk(input string tag, input bit ok,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_awready"}, AWREADY === 1'b0, 64'(AWREADY), 0);
    chk({p, "_wready"}, WREADY === 1'b0, 64'(WREADY), 0);
    chk({p, "_bvalid"}, BVALID === 1'b0, 64'(BVALID), 0);
    chk({p, "_arready"}, ARREADY === 1'b0, 64'(ARREADY), 0);
    chk({p, "_rvalid"}, RVALID === 1'b0, 64'(RVALID), 0);
    chk({p, "_rlast"}, RLAST === 1'b0, 64'(RLAST), 0);
    chk({p, "_rid"}, RID === 4'd0, 64'(RID), 0);
    chk({p, "_bid"}, BID === 4'd0, 64'(BID), 0);
    chk({p, "_rdata"}, RDATA === 32'd0, 64'(RDATA), 0);
    chk({p, "_perr"}, protocol_err === 1'b0,
        64'(protocol_err), 0);
  endtask

  task automatic do_write(input logic [3:0] id, input int addr,
                          input logic [3:0] len, input bit bad0,
                          input bit gaps);
    int g;
    AWVALID = 1'b1;
    AWID    = id;
    AWADDR  = 26'(addr);
    AWLEN   = len;
    g = 0;
    while (AWREADY !== 1'b1 && g < 100) begin tick; g++; end
    chk("aw_wait", g < 100, 64'(g), 100);
    tick;
    AWVALID = 1'b0;
    chk("wready_after_aw", WREADY === 1'b1, 64'(WREADY), 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick;
      WVALID = 1'b1;
      WDATA  = wbuf[i];
      WID    = id;
      WLAST  = (i == int'(len)) ^ (bad0 && i == 0);
      g = 0;
      while (WREADY !== 1'b1 && g < 100) begin tick; g++; end
      chk("w_wait", g < 100, 64'(g), 100);
      tick;
      WVALID = 1'b0;
      WLAST  = 1'b0;
      ref_mem[(addr / 4 + i) % DEPTH] = wbuf[i];
    end
    chk("bvalid", BVALID === 1'b1, 64'(BVALID), 1);
    chk("bid", BID === id, 64'(BID), 64'(id));
    BREADY = 1'b1;
    tick;
    BREADY = 1'b0;
    chk("b_done", BVALID === 1'b0, 64'(BVALID), 0);
    chk("awready_turn", AWREADY === 1'b1, 64'(AWREADY), 1);
  endtask

  task automatic do_read(input logic [3:0] id, input int addr,
                         input logic [3:0] len, input int mode);
    int g, lat, beats, base;
    bit held;
    logic [31:0] hd;
    logic [31:0] ev;
    logic hl;
    logic el;
    base = addr / 4;
    RREADY  = (mode == 1);
    ARVALID = 1'b1;
    ARID    = id;
    ARADDR  = 26'(addr);
    ARLEN   = len;
    g = 0;
    while (ARREADY !== 1'b1 && g < 100) begin tick; g++; end
    chk("ar_wait", g < 100, 64'(g), 100);
    tick;
    ARVALID = 1'b0;
    lat = 1;
    g = 0;
    while (RVALID !== 1'b1 && g < 100) begin
      tick; lat++; g++;
    end
    chk("r_latency", lat == RLAT, 64'(lat), 64'(RLAT));
    beats = 0;
    held  = 1'b0;
    hd    = '0;
    hl    = 1'b0;
    g     = 0;
    while (beats <= int'(len) && g < 200) begin
      if (RVALID === 1'b1) begin
        chk("rid", RID === id, 64'(RID), 64'(id));
        if (held) begin
          chk("rdata_hold", RDATA === hd, 64'(RDATA), 64'(hd));
          chk("rlast_hold", RLAST === hl, 64'(RLAST), 64'(hl));
        end
        case (mode)
          0:       RREADY = 1'b1;
          1:       RREADY = ~RREADY;
          default: RREADY = 1'($urandom_range(0, 1));
        endcase
        if (RREADY) begin
          ev = ref_mem[(base + beats) % DEPTH];
          el = (beats == int'(len));
          chk("rdata", RDATA === ev, 64'(RDATA), 64'(ev));
          chk("rlast", RLAST === el, 64'(RLAST), 64'(el));
          beats++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = RDATA;
          hl   = RLAST;
        end
      end else begin
        RREADY = 1'b0;
      end
      tick;
      g++;
    end
    RREADY = 1'b0;
    chk("r_beats", beats == int'(len) + 1,
        64'(beats), 64'(int'(len) + 1));
    chk("arready_turn", ARREADY === 1'b1, 64'(ARREADY), 1);
    chk("r_done", RVALID === 1'b0, 64'(RVALID), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    int g;
    logic [3:0] rl;
    int w;
    rst = 1'b1;
    AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
    WVALID = 0; WLAST = 0; WID = 0; WDATA = 0;
    BREADY = 0;
    ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0;
    RREADY = 0;
    repeat (3) tick;
    check_zero("rst0");
    rst = 1'b0;
    tick;
    chk("arready_post_rst", ARREADY === 1'b1, 64'(ARREADY), 1);
    chk("awready_post_rst", AWREADY === 1'b1, 64'(AWREADY), 1);

    wbuf[0] = 32'hDEADBEEF;
    do_write(4'd3, 32'h40, 4'd0, 1'b0, 1'b0);
    do_read(4'd5, 32'h40, 4'd0, 0);

    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(4'd1, (DEPTH - 2) * 4, 4'd3, 1'b0, 1'b0);
    chk("wrap_model_w0", ref_mem[0] === 32'd3,
        64'(ref_mem[0]), 3);
    do_read(4'd2, (DEPTH - 2) * 4, 4'd3, 0);

    do_read(4'd4, (DEPTH - 2) * 4, 4'd3, 1);

    chk("perr_clear", protocol_err === 1'b0,
        64'(protocol_err), 0);
    wbuf[0] = 32'hA0A0A0A0;
    wbuf[1] = 32'hB1B1B1B1;
    do_write(4'd6, 32'h100, 4'd1, 1'b1, 1'b0);
    chk("perr_set", protocol_err === 1'b1,
        64'(protocol_err), 1);
    do_read(4'd6, 32'h100, 4'd1, 0);

    for (int n = 0; n < 8; n++) begin
      rl = 4'($urandom_range(0, 15));
      w  = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      do_write(4'($urandom), w * 4 + $urandom_range(0, 3),
               rl, 1'b0, 1'b1);
      do_read(4'($urandom), w * 4 + $urandom_range(0, 3),
              rl, 2);
    end
    chk("perr_sticky", protocol_err === 1'b1,
        64'(protocol_err), 1);

    wbuf[0] = 32'h11;
    do_write(4'd1, 32, 4'd0, 1'b0, 1'b0);
    ARVALID = 1; ARID = 4'd2; ARADDR = 26'd32; ARLEN = 0;
    AWVALID = 1; AWID = 4'd7; AWADDR = 26'd32; AWLEN = 0;
    chk("coll_arready", ARREADY === 1'b1, 64'(ARREADY), 1);
    chk("coll_awready", AWREADY === 1'b1, 64'(AWREADY), 1);
    old = ref_mem[8];
    tick;
    ARVALID = 0;
    AWVALID = 0;
    repeat (RLAT - 2) tick;
    WVALID = 1; WDATA = 32'h22; WLAST = 1; WID = 4'd7;
    chk("coll_wready", WREADY === 1'b1, 64'(WREADY), 1);
    tick;
    WVALID = 0;
    WLAST  = 0;
    ref_mem[8] = 32'h22;
    chk("coll_rvalid", RVALID === 1'b1, 64'(RVALID), 1);
    chk("coll_rdata_old", RDATA === old, 64'(RDATA), 64'(old));
    chk("coll_rlast", RLAST === 1'b1, 64'(RLAST), 1);
    chk("coll_rid", RID === 4'd2, 64'(RID), 2);
    chk("coll_bvalid", BVALID === 1'b1, 64'(BVALID), 1);
    chk("coll_bid", BID === 4'd7, 64'(BID), 7);
    RREADY = 1;
    BREADY = 1;
    tick;
    RREADY = 0;
    BREADY = 0;
    chk("coll_arready_back", ARREADY === 1'b1,
        64'(ARREADY), 1);
    chk("coll_awready_back", AWREADY === 1'b1,
        64'(AWREADY), 1);
    do_read(4'd3, 32, 4'd0, 0);

    ARVALID = 1; ARID = 4'd8;
    ARADDR = 26'((DEPTH - 2) * 4); ARLEN = 4'd3;
    tick;
    ARVALID = 0;
    g = 0;
    while (RVALID !== 1'b1 && g < 100) begin tick; g++; end
    chk("mid_rvalid_wait", g < 100, 64'(g), 100);
    RREADY = 1;
    tick;
    chk("mid_rvalid_before_rst", RVALID === 1'b1,
        64'(RVALID), 1);
    rst = 1;
    tick;
    check_zero("rst1");
    tick;
    check_zero("rst2");
    RREADY = 0;
    rst = 0;
    tick;
    chk("arready_after_rst", ARREADY === 1'b1,
        64'(ARREADY), 1);
    chk("awready_after_rst", AWREADY === 1'b1,
        64'(AWREADY), 1);
    do_read(4'd9, 32, 4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
